// File: rtl/mp64_sram_arb.sv
// rtl/mp64_sram_arb.sv - two-port round-robin SRAM arbiter with priority lock and tagged read return
module mp64_sram_arb #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 512,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic              last_q;
  logic              locked_q;
  logic              lock_port_q;
  logic [RD_LAT-1:0] pipe_v_q;
  logic [RD_LAT-1:0] pipe_id_q;

  logic lock_hold;
  logic win_lock;
  logic rd_push;

  // The lock only holds while its owner keeps both req and lock high;
  // otherwise this very cycle falls back to round-robin.
  always_comb begin
    lock_hold = 1'b0;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    if (locked_q) begin
      lock_hold = (lock_port_q == PORT_A) ? (a_req && a_lock) : (b_req && b_lock);
    end
    if (rst_n) begin
      if (a_req && b_req) begin
        if (lock_hold) begin
          a_gnt = (lock_port_q == PORT_A);
        end else begin
          a_gnt = (last_q == PORT_B);
        end
        b_gnt = !a_gnt;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_comb begin
    sram_ce    = a_gnt || b_gnt;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (a_gnt) begin
      sram_we    = a_we;
      sram_addr  = a_addr;
      sram_wdata = a_wdata;
    end else if (b_gnt) begin
      sram_we    = b_we;
      sram_addr  = b_addr;
      sram_wdata = b_wdata;
    end
  end

  assign win_lock = (a_gnt && a_lock) || (b_gnt && b_lock);
  assign rd_push  = sram_ce && !sram_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= PORT_B;
      locked_q    <= 1'b0;
      lock_port_q <= PORT_A;
      pipe_v_q    <= '0;
      pipe_id_q   <= '0;
    end else begin
      if (sram_ce) begin
        last_q <= b_gnt;
      end
      if (win_lock) begin
        locked_q    <= 1'b1;
        lock_port_q <= b_gnt;
      end else if (!lock_hold) begin
        locked_q <= 1'b0;
      end
      pipe_v_q[0]  <= rd_push;
      pipe_id_q[0] <= b_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i]  <= pipe_v_q[i-1];
        pipe_id_q[i] <= pipe_id_q[i-1];
      end
    end
  end

  // Gated by rst_n so a stale pipe entry cannot leak out during the reset cycle.
  assign a_rvalid = rst_n && pipe_v_q[RD_LAT-1] && !pipe_id_q[RD_LAT-1];
  assign b_rvalid = rst_n && pipe_v_q[RD_LAT-1] && pipe_id_q[RD_LAT-1];
  assign rdata    = sram_rdata;

endmodule
